// File: rtl/z2_pkg.sv
// z2_pkg
//    Shared definitions for the Zorro II cycle controller: the state
//    encoding seen on z2_state, the state and error-counter widths, and a
//    saturating increment helper for the error counter.
package z2_pkg;

   localparam int STATE_W   = 3;
   localparam int ERR_CNT_W = 8;

   // Encodings are visible on the z2_state port, so they are fixed explicitly.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_END   = 3'd3,
      ST_ERR   = 3'd4
   } z2_state_t;

   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   // Error counter sticks at its maximum instead of wrapping back to zero.
   function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] value);
      return (value == ERR_CNT_MAX) ? value : value + ERR_CNT_W'(1);
   endfunction

endpackage

// File: rtl/z2_sync.sv
// z2_sync
//    Multi-flop synchroniser for one raw asynchronous 68000 bus strobe.
//    Every stage resets to 1 (the strobe's inactive level), so after reset
//    a low strobe has to walk the whole chain before it is seen.
//
// Ports
//    clk   in   sampling clock
//    rst   in   asynchronous active-high reset, forces all stages to 1
//    d     in   raw asynchronous strobe
//    q     out  last synchroniser stage
module z2_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift register: stage 0 samples the raw pin, the top stage is the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '1;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/z2_cycle_ctrl.sv
// z2_cycle_ctrl
//    Zorro II slave-side bus cycle controller. Synchronises the 68000
//    strobes, picks one owning target per cycle from the address decoders,
//    waits for that target's ready (or acknowledges fast targets at once),
//    and raises a bus error when a cycle stalls too long.
//
// Ports
//    MEMCLK     in   sole clock, all state on rising edge
//    RESET      in   asynchronous active-high reset
//    AS_n       in   raw address strobe
//    UDS_n      in   raw upper data strobe
//    LDS_n      in   raw lower data strobe
//    RW         in   raw read/write
//    sel        in   per-target address-decode hit
//    ready      in   per-target data-ready acknowledge
//    as_sync    out  synchronised AS_n
//    uds_sync   out  synchronised UDS_n
//    lds_sync   out  synchronised LDS_n
//    rw_sync    out  synchronised RW
//    z2_state   out  current state encoding
//    grant      out  one-hot owner of the current cycle
//    dtack      out  data-transfer acknowledge request
//    berr       out  bus-error request
//    ovr        out  override request, high whenever a cycle is in progress
//    err_count  out  saturating count of timed-out cycles
module z2_cycle_ctrl
   import z2_pkg::*;
#(
   parameter int                     NUM_TARGETS    = 5,
   parameter int                     AS_SYNC_STAGES = 3,
   parameter int                     DS_SYNC_STAGES = 2,
   parameter int                     TIMEOUT_CYCLES = 64,
   parameter logic [NUM_TARGETS-1:0] FAST_MASK      = '0
) (
   input  logic                   MEMCLK,
   input  logic                   RESET,
   input  logic                   AS_n,
   input  logic                   UDS_n,
   input  logic                   LDS_n,
   input  logic                   RW,
   input  logic [NUM_TARGETS-1:0] sel,
   input  logic [NUM_TARGETS-1:0] ready,
   output logic                   as_sync,
   output logic                   uds_sync,
   output logic                   lds_sync,
   output logic                   rw_sync,
   output logic [STATE_W-1:0]     z2_state,
   output logic [NUM_TARGETS-1:0] grant,
   output logic                   dtack,
   output logic                   berr,
   output logic                   ovr,
   output logic [ERR_CNT_W-1:0]   err_count
);

   // A zero timeout disables the timer; keep it one bit wide so it still exists.
   localparam int TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST =
      (TIMEOUT_CYCLES > 0) ? TIMER_W'(TIMEOUT_CYCLES - 1) : '0;

   z2_state_t              state;
   z2_state_t              state_next;
   logic [NUM_TARGETS-1:0] grant_next;
   logic [NUM_TARGETS-1:0] sel_lowest;
   logic [TIMER_W-1:0]     timer;
   logic [TIMER_W-1:0]     timer_next;
   logic [ERR_CNT_W-1:0]   err_next;
   logic                   ack_hit;
   logic                   timeout_hit;

   z2_sync #(.STAGES(AS_SYNC_STAGES)) u_sync_as  (.clk(MEMCLK), .rst(RESET), .d(AS_n),  .q(as_sync));
   z2_sync #(.STAGES(DS_SYNC_STAGES)) u_sync_uds (.clk(MEMCLK), .rst(RESET), .d(UDS_n), .q(uds_sync));
   z2_sync #(.STAGES(DS_SYNC_STAGES)) u_sync_lds (.clk(MEMCLK), .rst(RESET), .d(LDS_n), .q(lds_sync));
   z2_sync #(.STAGES(DS_SYNC_STAGES)) u_sync_rw  (.clk(MEMCLK), .rst(RESET), .d(RW),    .q(rw_sync));

   // x & -x isolates the lowest set bit, giving fixed lowest-index priority.
   assign sel_lowest = sel & (~sel + NUM_TARGETS'(1));

   // Only the latched owner can acknowledge; fast targets acknowledge unconditionally.
   assign ack_hit = |(grant & (ready | FAST_MASK));

   // The timer reads TIMER_LAST during the final allowed cycle, so the ERR
   // transition lands on the edge where the count reaches TIMEOUT_CYCLES.
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && (timer >= TIMER_LAST);

   // Next-state logic. Releasing AS always aborts first; in DATA an
   // acknowledge beats a timeout arriving on the same cycle.
   always_comb begin
      state_next = state;
      grant_next = grant;
      timer_next = timer;
      err_next   = err_count;
      unique case (state)
         ST_IDLE: begin
            grant_next = '0;
            if (!as_sync && (|sel)) begin
               state_next = ST_START;
               grant_next = sel_lowest;
               timer_next = '0;
            end
         end
         ST_START: begin
            timer_next = timer + TIMER_W'(1);
            if (as_sync) begin
               state_next = ST_IDLE;
               grant_next = '0;
            end else if (timeout_hit) begin
               state_next = ST_ERR;
               err_next   = err_sat_inc(err_count);
            end else if (!uds_sync || !lds_sync) begin
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            timer_next = timer + TIMER_W'(1);
            if (as_sync) begin
               state_next = ST_IDLE;
               grant_next = '0;
            end else if (ack_hit) begin
               state_next = ST_END;
            end else if (timeout_hit) begin
               state_next = ST_ERR;
               err_next   = err_sat_inc(err_count);
            end
         end
         ST_END, ST_ERR: begin
            if (as_sync) begin
               state_next = ST_IDLE;
               grant_next = '0;
            end
         end
         default: begin
            state_next = ST_IDLE;
            grant_next = '0;
         end
      endcase
   end

   // State, owner, timer and error counter registers.
   always_ff @(posedge MEMCLK or posedge RESET) begin
      if (RESET) begin
         state     <= ST_IDLE;
         grant     <= '0;
         timer     <= '0;
         err_count <= '0;
      end else begin
         state     <= state_next;
         grant     <= grant_next;
         timer     <= timer_next;
         err_count <= err_next;
      end
   end

   // Bus requests decode straight from the state register, so they can never
   // overlap and drop the instant reset is asserted.
   assign z2_state = state;
   assign dtack    = (state == ST_END);
   assign berr     = (state == ST_ERR);
   assign ovr      = (state != ST_IDLE);

endmodule

// File: tb/tb_z2_cycle_ctrl.sv
// tb_z2_cycle_ctrl
//    Directed bench for z2_cycle_ctrl. Expected cycle outcomes are queued
//    when a bus cycle is started and compared when the controller reaches
//    END or ERR; timing-specific behaviour is checked inline.
module tb_z2_cycle_ctrl;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_END   = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   logic       MEMCLK;
   logic       RESET;
   logic       AS_n;
   logic       UDS_n;
   logic       LDS_n;
   logic       RW;
   logic [4:0] sel;
   logic [4:0] ready;
   logic       as_sync;
   logic       uds_sync;
   logic       lds_sync;
   logic       rw_sync;
   logic [2:0] z2_state;
   logic [4:0] grant;
   logic       dtack;
   logic       berr;
   logic       ovr;
   logic [7:0] err_count;

   int checks = 0;
   int errors = 0;
   int cyc;

   typedef struct {
      logic [4:0] grant;
      logic       dtack;
      logic       berr;
      logic [7:0] errc;
   } exp_t;

   exp_t sb[$];

   z2_cycle_ctrl #(
      .NUM_TARGETS   (5),
      .AS_SYNC_STAGES(3),
      .DS_SYNC_STAGES(2),
      .TIMEOUT_CYCLES(64),
      .FAST_MASK     (5'b10000)
   ) dut (
      .MEMCLK   (MEMCLK),
      .RESET    (RESET),
      .AS_n     (AS_n),
      .UDS_n    (UDS_n),
      .LDS_n    (LDS_n),
      .RW       (RW),
      .sel      (sel),
      .ready    (ready),
      .as_sync  (as_sync),
      .uds_sync (uds_sync),
      .lds_sync (lds_sync),
      .rw_sync  (rw_sync),
      .z2_state (z2_state),
      .grant    (grant),
      .dtack    (dtack),
      .berr     (berr),
      .ovr      (ovr),
      .err_count(err_count)
   );

   initial MEMCLK = 1'b0;
   always #5 MEMCLK = ~MEMCLK;

   // Hard stop in case a bounded wait is somehow bypassed.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge MEMCLK);
      #1;
   endtask

   task automatic waitState(input logic [2:0] st, input int budget, input string tag);
      int n;
      n = 0;
      while (z2_state !== st && n < budget) begin
         tick();
         n++;
      end
      checkOutput(tag, 32'(z2_state), 32'(st));
   endtask

   // Starts a read cycle and, if requested, queues the outcome it should produce.
   task automatic applyStimulus(input logic [4:0] sel_v, input bit push, input logic [4:0] g,
                                input logic d, input logic b, input logic [7:0] ec);
      exp_t e;
      if (push) begin
         e.grant = g;
         e.dtack = d;
         e.berr  = b;
         e.errc  = ec;
         sb.push_back(e);
      end
      sel   = sel_v;
      RW    = 1'b1;
      AS_n  = 1'b0;
      UDS_n = 1'b0;
      LDS_n = 1'b0;
   endtask

   task automatic waitOutcome(input string tag, input int budget, output int cycles);
      exp_t e;
      cycles = 0;
      while (z2_state !== S_END && z2_state !== S_ERR && cycles < budget) begin
         tick();
         cycles++;
      end
      checkOutput({tag, "_done"}, 32'(z2_state == S_END || z2_state == S_ERR), 32'd1);
      checkOutput({tag, "_excl"}, 32'(dtack & berr), 32'd0);
      if (sb.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         checkOutput({tag, "_grant"}, 32'(grant), 32'(e.grant));
         checkOutput({tag, "_dtack"}, 32'(dtack), 32'(e.dtack));
         checkOutput({tag, "_berr"},  32'(berr),  32'(e.berr));
         checkOutput({tag, "_errc"},  32'(err_count), 32'(e.errc));
      end
   endtask

   task automatic endCycle(input string tag);
      AS_n  = 1'b1;
      UDS_n = 1'b1;
      LDS_n = 1'b1;
      ready = '0;
      sel   = '0;
      waitState(S_IDLE, 10, {tag, "_idle"});
      checkOutput({tag, "_grant0"}, 32'(grant), 32'd0);
      checkOutput({tag, "_dtack0"}, 32'(dtack), 32'd0);
      checkOutput({tag, "_berr0"},  32'(berr),  32'd0);
   endtask

   initial begin
      RESET = 1'b1;
      AS_n  = 1'b0;
      UDS_n = 1'b1;
      LDS_n = 1'b1;
      RW    = 1'b1;
      sel   = '0;
      ready = '0;

      // Reset state, with AS_n low to show the synchroniser is held at 1.
      tick();
      tick();
      checkOutput("rst_state", 32'(z2_state), 32'(S_IDLE));
      checkOutput("rst_grant", 32'(grant), 32'd0);
      checkOutput("rst_dtack", 32'(dtack), 32'd0);
      checkOutput("rst_berr",  32'(berr), 32'd0);
      checkOutput("rst_ovr",   32'(ovr), 32'd0);
      checkOutput("rst_errc",  32'(err_count), 32'd0);
      checkOutput("rst_as",    32'(as_sync), 32'd1);
      AS_n  = 1'b1;
      RESET = 1'b0;
      tick();
      tick();
      tick();
      tick();

      // Read to target 2: synchroniser latency, grant, ready four cycles into DATA.
      applyStimulus(5'b00100, 1'b1, 5'b00100, 1'b1, 1'b0, 8'd0);
      tick();
      tick();
      checkOutput("t2_as_lat2", 32'(as_sync), 32'd1);
      checkOutput("t2_uds_lat", 32'(uds_sync), 32'd0);
      tick();
      checkOutput("t2_as_lat3", 32'(as_sync), 32'd0);
      checkOutput("t2_idle", 32'(z2_state), 32'(S_IDLE));
      tick();
      checkOutput("t2_start", 32'(z2_state), 32'(S_START));
      checkOutput("t2_grant", 32'(grant), 32'd4);
      checkOutput("t2_ovr", 32'(ovr), 32'd1);
      tick();
      checkOutput("t2_data", 32'(z2_state), 32'(S_DATA));
      tick();
      tick();
      tick();
      checkOutput("t2_wait", 32'(z2_state), 32'(S_DATA));
      checkOutput("t2_nodtack", 32'(dtack), 32'd0);
      ready = 5'b00100;
      waitOutcome("t2", 3, cyc);
      checkOutput("t2_ack_lat", 32'(cyc), 32'd1);
      tick();
      tick();
      checkOutput("t2_hold", 32'(dtack), 32'd1);
      AS_n  = 1'b1;
      UDS_n = 1'b1;
      LDS_n = 1'b1;
      tick();
      tick();
      tick();
      checkOutput("t2_hold_as", 32'(dtack), 32'd1);
      checkOutput("t2_as_hi", 32'(as_sync), 32'd1);
      tick();
      checkOutput("t2_rel_state", 32'(z2_state), 32'(S_IDLE));
      checkOutput("t2_rel_dtack", 32'(dtack), 32'd0);
      checkOutput("t2_rel_grant", 32'(grant), 32'd0);
      endCycle("t2");

      // Priority pick and sel changes ignored once the owner is latched.
      applyStimulus(5'b01010, 1'b1, 5'b00010, 1'b1, 1'b0, 8'd0);
      waitState(S_START, 10, "t3_start");
      checkOutput("t3_grant", 32'(grant), 32'd2);
      sel = 5'b00000;
      tick();
      sel = 5'b10000;
      waitState(S_DATA, 5, "t3_data");
      tick();
      tick();
      checkOutput("t3_grant_held", 32'(grant), 32'd2);
      ready = 5'b00001;
      tick();
      tick();
      tick();
      checkOutput("t3_foreign_ready", 32'(z2_state), 32'(S_DATA));
      ready = 5'b00010;
      waitOutcome("t3", 3, cyc);
      checkOutput("t3_ack_lat", 32'(cyc), 32'd1);
      endCycle("t3");

      // Fast target 4 acknowledges on the first DATA edge without ready.
      applyStimulus(5'b10000, 1'b1, 5'b10000, 1'b1, 1'b0, 8'd0);
      waitState(S_DATA, 10, "t4_data");
      waitOutcome("t4", 3, cyc);
      checkOutput("t4_ack_lat", 32'(cyc), 32'd1);
      endCycle("t4");

      // Timeout: berr on the 64th START/DATA cycle, counter 0 -> 1.
      applyStimulus(5'b00001, 1'b1, 5'b00001, 1'b0, 1'b1, 8'd1);
      waitState(S_START, 10, "t5_start");
      waitOutcome("t5", 100, cyc);
      checkOutput("t5_cycles", 32'(cyc), 32'd64);
      tick();
      tick();
      checkOutput("t5_berr_hold", 32'(berr), 32'd1);
      checkOutput("t5_dtack_off", 32'(dtack), 32'd0);
      endCycle("t5");

      // AS released during DATA: abort wins over a ready arriving with it.
      applyStimulus(5'b00100, 1'b0, 5'b0, 1'b0, 1'b0, 8'd0);
      waitState(S_DATA, 10, "t6_data");
      AS_n = 1'b1;
      tick();
      checkOutput("t6_dtack_a", 32'(dtack), 32'd0);
      tick();
      checkOutput("t6_dtack_b", 32'(dtack), 32'd0);
      tick();
      checkOutput("t6_still_data", 32'(z2_state), 32'(S_DATA));
      checkOutput("t6_as_hi", 32'(as_sync), 32'd1);
      ready = 5'b00100;
      tick();
      checkOutput("t6_abort", 32'(z2_state), 32'(S_IDLE));
      checkOutput("t6_no_dtack", 32'(dtack), 32'd0);
      endCycle("t6");

      // Reset pulsed in END clears everything at once, then full resync.
      applyStimulus(5'b00100, 1'b1, 5'b00100, 1'b1, 1'b0, 8'd1);
      ready = 5'b00100;
      waitOutcome("t7", 20, cyc);
      #3;
      RESET = 1'b1;
      #1;
      checkOutput("t7_state", 32'(z2_state), 32'(S_IDLE));
      checkOutput("t7_dtack", 32'(dtack), 32'd0);
      checkOutput("t7_grant", 32'(grant), 32'd0);
      checkOutput("t7_ovr",   32'(ovr), 32'd0);
      checkOutput("t7_errc",  32'(err_count), 32'd0);
      checkOutput("t7_as",    32'(as_sync), 32'd1);
      #2;
      RESET = 1'b0;
      ready = '0;
      tick();
      tick();
      tick();
      checkOutput("t7_no_early_start", 32'(z2_state), 32'(S_IDLE));
      tick();
      checkOutput("t7_restart", 32'(z2_state), 32'(S_START));
      endCycle("t7");

      // 256 timeouts from zero: counter saturates at 255.
      for (int i = 0; i < 256; i++) begin
         applyStimulus(5'b00001, 1'b1, 5'b00001, 1'b0, 1'b1, 8'((i + 1 > 255) ? 255 : i + 1));
         waitOutcome("t8", 120, cyc);
         endCycle("t8");
      end
      checkOutput("t8_sat", 32'(err_count), 32'd255);

      checkOutput("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
